// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: a byte FIFO feeding an LSB-first serialiser with
// optional parity and one or two stop bits. All line-facing outputs are registered.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_tx_valid,
    input  logic [7:0]                  i_tx_byte,
    output logic                        o_tx_ready,
    output logic                        o_tx_serial,
    output logic                        o_tx_active,
    output logic                        o_tx_done,
    output logic [$clog2(FIFO_DEPTH):0] o_fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_MAX  = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic          STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;
    localparam logic          ODD_C     = (PARITY_ODD != 0) ? 1'b1 : 1'b0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    state_e        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic          stop_cnt_q, stop_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          serial_q, serial_d;
    logic          active_q, active_d;
    logic          done_q, done_d;
    logic          push_s, pop_s, tick_s, fifo_nonempty_s;

    assign o_tx_ready      = (count_q < DEPTH_C);
    assign push_s          = i_tx_valid && o_tx_ready;
    assign tick_s          = (baud_q == BAUD_MAX);
    assign fifo_nonempty_s = (count_q != {CW{1'b0}});

    // FIFO storage; contents need no reset because the pointers define validity
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= i_tx_byte;
        end
    end

    // FIFO pointer and occupancy next-state
    always_comb begin
        wr_ptr_d = push_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
        rd_ptr_d = pop_s  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // State register and all registered datapath/outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= {AW{1'b0}};
            rd_ptr_q   <= {AW{1'b0}};
            count_q    <= {CW{1'b0}};
            state_q    <= IDLE;
            baud_q     <= {BW{1'b0}};
            bit_idx_q  <= 3'd0;
            stop_cnt_q <= 1'b0;
            shift_q    <= 8'h00;
            serial_q   <= 1'b1;
            active_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            stop_cnt_q <= stop_cnt_d;
            shift_q    <= shift_d;
            serial_q   <= serial_d;
            active_q   <= active_d;
            done_q     <= done_d;
        end
    end

    // Next-state: frame sequencing, baud counting and FIFO pop
    always_comb begin
        state_d    = state_q;
        baud_d     = tick_s ? {BW{1'b0}} : (baud_q + BW'(1));
        bit_idx_d  = bit_idx_q;
        stop_cnt_d = stop_cnt_q;
        shift_d    = shift_q;
        pop_s      = 1'b0;
        case (state_q)
            IDLE: begin
                baud_d = {BW{1'b0}};
                if (fifo_nonempty_s) begin
                    pop_s     = 1'b1;
                    shift_d   = mem_q[rd_ptr_q];
                    bit_idx_d = 3'd0;
                    state_d   = START;
                end else begin
                    state_d   = IDLE;
                end
            end
            START: begin
                if (tick_s) begin
                    bit_idx_d = 3'd0;
                    state_d   = DATA;
                end else begin
                    state_d   = START;
                end
            end
            DATA: begin
                if (tick_s && (bit_idx_q == 3'd7)) begin
                    stop_cnt_d = 1'b0;
                    state_d    = (PARITY_EN != 0) ? PARITY : STOP;
                end else if (tick_s) begin
                    bit_idx_d  = bit_idx_q + 3'd1;
                end else begin
                    state_d    = DATA;
                end
            end
            PARITY: begin
                if (tick_s) begin
                    stop_cnt_d = 1'b0;
                    state_d    = STOP;
                end else begin
                    state_d    = PARITY;
                end
            end
            STOP: begin
                // Final stop cycle chains straight into the next frame when data waits
                if (tick_s && (stop_cnt_q == STOP_LAST) && fifo_nonempty_s) begin
                    pop_s      = 1'b1;
                    shift_d    = mem_q[rd_ptr_q];
                    bit_idx_d  = 3'd0;
                    state_d    = START;
                end else if (tick_s && (stop_cnt_q == STOP_LAST)) begin
                    state_d    = IDLE;
                end else if (tick_s) begin
                    stop_cnt_d = 1'b1;
                end else begin
                    state_d    = STOP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs derived from next-state so the registered line tracks state_q
    always_comb begin
        case (state_d)
            IDLE:    serial_d = 1'b1;
            START:   serial_d = 1'b0;
            DATA:    serial_d = shift_d[bit_idx_d];
            PARITY:  serial_d = (^shift_d) ^ ODD_C;
            STOP:    serial_d = 1'b1;
            default: serial_d = 1'b1;
        endcase
        active_d = (state_d != IDLE);
        done_d   = (state_d == STOP) && (baud_d == BAUD_MAX) && (stop_cnt_d == STOP_LAST);
    end

    assign o_tx_serial  = serial_q;
    assign o_tx_active  = active_q;
    assign o_tx_done    = done_q;
    assign o_fifo_count = count_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: plain 8N1, parity/two-stop variants,
// back-to-back frames, FIFO overflow and asynchronous reset mid-frame.
module tb_uart_tx_fifo;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       valid_m, valid_pe, valid_po;
    logic [7:0] tx_byte;
    logic       ready_m, serial_m, active_m, done_m;
    logic       ready_pe, serial_pe, active_pe, done_pe;
    logic       ready_po, serial_po, active_po, done_po;
    logic [2:0] count_m, count_pe, count_po;

    int checks = 0;
    int errors = 0;
    logic [7:0] seq [0:7];
    logic [7:0] drv [0:7];

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut_m (
        .clk(clk), .rst_n(rst_n), .i_tx_valid(valid_m), .i_tx_byte(tx_byte), .o_tx_ready(ready_m),
        .o_tx_serial(serial_m), .o_tx_active(active_m), .o_tx_done(done_m), .o_fifo_count(count_m));

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut_pe (
        .clk(clk), .rst_n(rst_n), .i_tx_valid(valid_pe), .i_tx_byte(tx_byte), .o_tx_ready(ready_pe),
        .o_tx_serial(serial_pe), .o_tx_active(active_pe), .o_tx_done(done_pe), .o_fifo_count(count_pe));

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut_po (
        .clk(clk), .rst_n(rst_n), .i_tx_valid(valid_po), .i_tx_byte(tx_byte), .o_tx_ready(ready_po),
        .o_tx_serial(serial_po), .o_tx_active(active_po), .o_tx_done(done_po), .o_fifo_count(count_po));

    // Expected line level in bit slot k of a frame (0 = start bit)
    function automatic logic frame_bit(input logic [7:0] b, input int pe, input int po, input int k);
        if (k == 0)                   return 1'b0;
        else if (k <= 8)              return b[k-1];
        else if (pe != 0 && k == 9)   return (^b) ^ (po != 0);
        else                          return 1'b1;
    endfunction

    task automatic test_reset();
        rst_n = 1'b1; valid_m = 1'b0; valid_pe = 1'b0; valid_po = 1'b0; tx_byte = 8'h00;
        #1 rst_n = 1'b0;
        #1;
        checks++; if (serial_m !== 1'b1) begin errors++; $display("FAIL reset_serial got %b exp 1", serial_m); end
        checks++; if (active_m !== 1'b0) begin errors++; $display("FAIL reset_active got %b exp 0", active_m); end
        checks++; if (done_m !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done_m); end
        checks++; if (count_m !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count_m); end
        checks++; if (ready_m !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", ready_m); end
        checks++; if (serial_pe !== 1'b1 || serial_po !== 1'b1) begin errors++; $display("FAIL reset_serial_par got %b%b exp 11", serial_pe, serial_po); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (serial_m !== 1'b1 || active_m !== 1'b0) begin errors++; $display("FAIL post_reset_idle got %b%b exp 10", serial_m, active_m); end
    endtask

    task automatic test_single();
        logic exp;
        for (int c = 0; c <= 42; c++) begin
            @(negedge clk);
            if (c == 1) begin
                checks++; if (serial_m !== 1'b1 || count_m !== 3'd1) begin errors++; $display("FAIL single_latency got serial %b count %0d exp 1 1", serial_m, count_m); end
            end
            if (c >= 2 && c <= 41) begin
                exp = frame_bit(8'h55, 0, 0, (c - 2) / CPB);
                checks++; if (serial_m !== exp) begin errors++; $display("FAIL single_bit c=%0d got %b exp %b", c, serial_m, exp); end
                checks++; if (active_m !== 1'b1) begin errors++; $display("FAIL single_active c=%0d got %b exp 1", c, active_m); end
                checks++; if (done_m !== (c == 41)) begin errors++; $display("FAIL single_done c=%0d got %b exp %b", c, done_m, (c == 41)); end
            end
            if (c == 42) begin
                checks++; if (serial_m !== 1'b1 || active_m !== 1'b0 || count_m !== 3'd0) begin errors++; $display("FAIL single_end got %b %b %0d exp 1 0 0", serial_m, active_m, count_m); end
            end
            valid_m = (c == 0); tx_byte = 8'h55;
        end
    endtask

    task automatic test_back_to_back();
        logic exp;
        int i, ndone;
        ndone = 0;
        seq[0] = 8'hA3; seq[1] = 8'h0F; seq[2] = 8'hFF;
        for (int c = 0; c <= 122; c++) begin
            @(negedge clk);
            if (c >= 2 && c <= 121) begin
                i = c - 1;
                exp = frame_bit(seq[(i - 1) / 40], 0, 0, ((i - 1) % 40) / CPB);
                if (done_m === 1'b1) ndone++;
                checks++; if (serial_m !== exp) begin errors++; $display("FAIL b2b_bit i=%0d got %b exp %b", i, serial_m, exp); end
                checks++; if (active_m !== 1'b1) begin errors++; $display("FAIL b2b_active i=%0d got %b exp 1", i, active_m); end
                checks++; if (done_m !== ((i % 40) == 0)) begin errors++; $display("FAIL b2b_done i=%0d got %b", i, done_m); end
            end
            if (c == 122) begin
                checks++; if (ndone !== 3) begin errors++; $display("FAIL b2b_done_count got %0d exp 3", ndone); end
                checks++; if (serial_m !== 1'b1 || active_m !== 1'b0 || count_m !== 3'd0) begin errors++; $display("FAIL b2b_end got %b %b %0d exp 1 0 0", serial_m, active_m, count_m); end
            end
            valid_m = (c <= 2);
            if (c <= 2) tx_byte = seq[c];
        end
    endtask

    task automatic test_parity();
        logic exp;
        for (int c = 0; c <= 52; c++) begin
            @(negedge clk);
            if (c >= 2 && c <= 49) begin
                exp = frame_bit(8'h07, 1, 0, (c - 2) / CPB);
                checks++; if (serial_pe !== exp) begin errors++; $display("FAIL par_even_bit c=%0d got %b exp %b", c, serial_pe, exp); end
                checks++; if (done_pe !== (c == 49)) begin errors++; $display("FAIL par_even_done c=%0d got %b", c, done_pe); end
            end
            if (c >= 2 && c <= 45) begin
                exp = frame_bit(8'h07, 1, 1, (c - 2) / CPB);
                checks++; if (serial_po !== exp) begin errors++; $display("FAIL par_odd_bit c=%0d got %b exp %b", c, serial_po, exp); end
                checks++; if (done_po !== (c == 45)) begin errors++; $display("FAIL par_odd_done c=%0d got %b", c, done_po); end
            end
            if (c == 39) begin
                checks++; if (serial_pe !== 1'b1 || serial_po !== 1'b0) begin errors++; $display("FAIL par_bit_0x07 got even %b odd %b exp 1 0", serial_pe, serial_po); end
            end
            if (c == 46) begin
                checks++; if (active_po !== 1'b0 || active_pe !== 1'b1) begin errors++; $display("FAIL par_len_44 got odd %b even %b exp 0 1", active_po, active_pe); end
            end
            if (c == 50) begin
                checks++; if (active_pe !== 1'b0 || serial_pe !== 1'b1 || count_pe !== 3'd0) begin errors++; $display("FAIL par_len_48 got %b %b %0d exp 0 1 0", active_pe, serial_pe, count_pe); end
            end
            valid_pe = (c == 0); valid_po = (c == 0); tx_byte = 8'h07;
        end
    endtask

    // extra_hold: keep driving 0xEE through the pop edge of the first frame
    task automatic run_overflow(input int extra_hold);
        logic exp;
        int i, ndone;
        ndone = 0;
        seq[0] = 8'hB0; seq[1] = 8'h11; seq[2] = 8'h22; seq[3] = 8'h33; seq[4] = 8'h44;
        drv[0] = 8'h11; drv[1] = 8'h22; drv[2] = 8'h33; drv[3] = 8'h44; drv[4] = 8'h55; drv[5] = 8'h66;
        for (int c = 0; c <= 202; c++) begin
            @(negedge clk);
            if (c >= 2 && c <= 201) begin
                i = c - 1;
                exp = frame_bit(seq[(i - 1) / 40], 0, 0, ((i - 1) % 40) / CPB);
                if (done_m === 1'b1) ndone++;
                checks++; if (serial_m !== exp) begin errors++; $display("FAIL ovf%0d_bit i=%0d got %b exp %b", extra_hold, i, serial_m, exp); end
            end
            if (c == 5) begin
                checks++; if (ready_m !== 1'b1 || count_m !== 3'd3) begin errors++; $display("FAIL ovf%0d_c3 got ready %b count %0d exp 1 3", extra_hold, ready_m, count_m); end
            end
            if (c == 6 || c == 8) begin
                checks++; if (ready_m !== 1'b0 || count_m !== 3'd4) begin errors++; $display("FAIL ovf%0d_full c=%0d got ready %b count %0d exp 0 4", extra_hold, c, ready_m, count_m); end
            end
            if (extra_hold != 0 && c == 41) begin
                checks++; if (done_m !== 1'b1 || ready_m !== 1'b0 || count_m !== 3'd4) begin errors++; $display("FAIL popfull_pre got done %b ready %b count %0d exp 1 0 4", done_m, ready_m, count_m); end
            end
            if (extra_hold != 0 && c == 42) begin
                checks++; if (ready_m !== 1'b1 || count_m !== 3'd3) begin errors++; $display("FAIL popfull_post got ready %b count %0d exp 1 3", ready_m, count_m); end
            end
            if (c == 202) begin
                checks++; if (ndone !== 5) begin errors++; $display("FAIL ovf%0d_done_count got %0d exp 5", extra_hold, ndone); end
                checks++; if (serial_m !== 1'b1 || active_m !== 1'b0 || count_m !== 3'd0) begin errors++; $display("FAIL ovf%0d_end got %b %b %0d exp 1 0 0", extra_hold, serial_m, active_m, count_m); end
            end
            if (c == 0) begin
                valid_m = 1'b1; tx_byte = 8'hB0;
            end else if (c >= 2 && c <= 7 && (extra_hold == 0 || c <= 5)) begin
                valid_m = 1'b1; tx_byte = drv[c - 2];
            end else if (extra_hold != 0 && c >= 6 && c <= 41) begin
                valid_m = 1'b1; tx_byte = 8'hEE;
            end else begin
                valid_m = 1'b0;
            end
        end
    endtask

    task automatic test_overflow();
        run_overflow(0);
    endtask

    task automatic test_pop_at_full();
        run_overflow(1);
    endtask

    task automatic test_reset_mid_frame();
        for (int c = 0; c <= 19; c++) begin
            @(negedge clk);
            if (c == 19) begin
                checks++; if (serial_m !== 1'b0 || count_m !== 3'd2 || active_m !== 1'b1) begin errors++; $display("FAIL rstmid_pre got %b %0d %b exp 0 2 1", serial_m, count_m, active_m); end
            end
            valid_m = (c == 0 || c == 2 || c == 3);
            tx_byte = (c == 0) ? 8'hA5 : 8'h3C;
        end
        rst_n = 1'b0;
        #1;
        checks++; if (serial_m !== 1'b1) begin errors++; $display("FAIL rstmid_serial got %b exp 1", serial_m); end
        checks++; if (active_m !== 1'b0) begin errors++; $display("FAIL rstmid_active got %b exp 0", active_m); end
        checks++; if (count_m !== 3'd0 || ready_m !== 1'b1) begin errors++; $display("FAIL rstmid_count got %0d ready %b exp 0 1", count_m, ready_m); end
        @(negedge clk);
        valid_m = 1'b0;
        rst_n = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            checks++; if (serial_m !== 1'b1 || active_m !== 1'b0 || count_m !== 3'd0 || done_m !== 1'b0) begin errors++; $display("FAIL rstmid_idle c=%0d got %b %b %0d %b exp 1 0 0 0", c, serial_m, active_m, count_m, done_m); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_parity();
        test_overflow();
        test_pop_at_full();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
